// File: rtl/neural_soc_from_hw_port.sv
// Hardware-to-CPU result port: a valid/ready push FIFO drained over Avalon-MM, with a level IRQ.
// Optional push counter at address 3 when NEURAL_SOC_FROM_HW_PORT_PUSH_COUNT_EN is defined.
module neural_soc_from_hw_port #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready
);
  // Handshake: a word moves on any rising edge where in_valid and in_ready are both high;
  // in_ready depends only on the registered count, never on the bus.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CMP_W = (CNT_W > 4) ? CNT_W : 4;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              underflow_q, underflow_d;
  logic              irq_en_q, irq_en_d;
  logic [3:0]        thr_q, thr_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [DATA_W-1:0] status, control, aux;

  logic rd, wr, empty, full, push, pop, flush, unf_set, unf_clr;
  logic [CMP_W-1:0] cnt_cmp, thr_cmp;
  logic unused_wd;

  assign rd      = chipselect & ~read_n;
  assign wr      = chipselect & ~write_n;
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign push    = in_valid & ~full;
  assign pop     = rd & (address == 2'd0) & ~empty;
  assign unf_set = rd & (address == 2'd0) & empty;
  assign unf_clr = wr & (address == 2'd1) & writedata[2];
  assign flush   = wr & (address == 2'd3) & writedata[0];
  assign unused_wd = ^writedata;

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign in_ready = ~full;

`ifdef NEURAL_SOC_FROM_HW_PORT_PUSH_COUNT_EN
  logic [31:0] push_cnt_q;

  // Counts every accepted push, including ones a simultaneous flush discards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) push_cnt_q <= '0;
    else if (push) push_cnt_q <= push_cnt_q + 32'd1;
  end

  assign aux = DATA_W'(push_cnt_q);
`else
  assign aux = '0;
`endif

  always_comb begin
    status           = '0;
    status[0]        = empty;
    status[1]        = full;
    status[2]        = underflow_q;
    status[3]        = irq_q;
    status[8 +: CNT_W] = count_q;
    control          = '0;
    control[0]       = irq_en_q;
    control[11:8]    = thr_q;
  end

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    irq_en_d    = irq_en_q;
    thr_d       = thr_q;
    readdata_d  = readdata_q;

    if (rd) begin
      unique case (address)
        2'd0:    readdata_d = empty ? '0 : mem_q[rd_ptr_q];
        2'd1:    readdata_d = status;
        2'd2:    readdata_d = control;
        default: readdata_d = aux;
      endcase
    end

    // Flush overrides any concurrent push or pop.
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (unf_set)      underflow_d = 1'b1;
    else if (unf_clr) underflow_d = 1'b0;

    if (wr && address == 2'd2) begin
      irq_en_d = writedata[0];
      thr_d    = writedata[11:8];
    end

    cnt_cmp = CMP_W'(count_d);
    thr_cmp = (thr_q == 4'd0) ? CMP_W'(1) : CMP_W'(thr_q);
    irq_d   = irq_en_q & (cnt_cmp >= thr_cmp);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
      irq_en_q    <= 1'b0;
      thr_q       <= '0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      underflow_q <= underflow_d;
      irq_en_q    <= irq_en_d;
      thr_q       <= thr_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_neural_soc_from_hw_port.sv
// Bench for neural_soc_from_hw_port: directed test-plan scenarios plus random traffic
// checked each cycle against a queue-based model of the port.
module tb_neural_soc_from_hw_port;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;

  neural_soc_from_hw_port dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] exp_q[$];
  logic        m_unf, m_en, m_irq;
  logic [3:0]  m_thr;
  logic [31:0] m_rdata, m_pcnt;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_unf = 0; m_en = 0; m_irq = 0; m_thr = 0; m_rdata = 0; m_pcnt = 0;
  endtask

  // Apply the currently driven inputs to the model, clock once, then compare.
  task automatic tick();
    int sz, lim;
    logic rd_s, wr_s, acc, flush;
    logic [31:0] st;
    sz   = exp_q.size();
    rd_s = chipselect && !read_n;
    wr_s = chipselect && !write_n;
    acc  = in_valid && (sz < DEPTH);
    flush = wr_s && address == 2'd3 && writedata[0];
    if (rd_s) begin
      case (address)
        2'd0: m_rdata = (sz > 0) ? exp_q[0] : 32'h0;
        2'd1: begin
          st = 32'h0;
          st[0] = (sz == 0); st[1] = (sz == DEPTH); st[2] = m_unf; st[3] = m_irq;
          st[15:8] = 8'(sz);
          m_rdata = st;
        end
        2'd2: m_rdata = {20'h0, m_thr, 7'h0, m_en};
        default: begin
`ifdef NEURAL_SOC_FROM_HW_PORT_PUSH_COUNT_EN
          m_rdata = m_pcnt;
`else
          m_rdata = 32'h0;
`endif
        end
      endcase
    end
    if (flush) exp_q.delete();
    else begin
      if (rd_s && address == 2'd0 && sz > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(in_data);
    end
    if (acc) m_pcnt = m_pcnt + 1;
    if (rd_s && address == 2'd0 && sz == 0) m_unf = 1;
    else if (wr_s && address == 2'd1 && writedata[2]) m_unf = 0;
    lim = (m_thr == 0) ? 1 : int'(m_thr);
    m_irq = m_en && (exp_q.size() >= lim);
    if (wr_s && address == 2'd2) begin
      m_en  = writedata[0];
      m_thr = writedata[11:8];
    end
    @(posedge clk);
    #1;
    check("readdata", readdata, m_rdata);
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("in_ready", {31'h0, in_ready}, {31'h0, exp_q.size() < DEPTH});
  endtask

  // op: 0 idle, 1 read, 2 write
  task automatic cyc(input logic v, input logic [31:0] d, input int op,
                     input logic [1:0] a, input logic [31:0] wd);
    in_valid   = v;
    in_data    = d;
    chipselect = (op != 0);
    read_n     = (op != 1);
    write_n    = (op != 2);
    address    = a;
    writedata  = wd;
    tick();
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    cyc(0, 0, 1, 2'd1, 0);
    check(tag, readdata, exp);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cyc(0, 0, 1, 2'd0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    // Three pushes then in-order reads
    for (int i = 1; i <= 3; i++) cyc(1, 32'hA5A5_0000 + i, 0, 2'd0, 0);
    read_status("t1_status3", 32'h0000_0300);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 2'd0, 0);
      check("t1_data", readdata, 32'hA5A5_0000 + i);
    end
    read_status("t1_empty", 32'h0000_0001);

    // Fill to full, 9th word waits for a pop
    for (int i = 0; i < 8; i++) cyc(1, 32'h1000 + i, 0, 2'd0, 0);
    check("t2_full_ready", {31'h0, in_ready}, 32'h0);
    cyc(1, 32'h1008, 1, 2'd0, 0);
    check("t2_first", readdata, 32'h1000);
    cyc(1, 32'h1008, 0, 2'd0, 0);
    in_valid = 0;
    read_status("t2_count8", 32'h0000_0802);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 2'd0, 0);
      check("t2_order", readdata, 32'h1000 + i);
    end

    // Underflow sticky and clear
    cyc(0, 0, 1, 2'd0, 0);
    check("t3_underflow_data", readdata, 32'h0);
    read_status("t3_unf_set", 32'h0000_0005);
    cyc(0, 0, 2, 2'd1, 32'h4);
    read_status("t3_unf_clr", 32'h0000_0001);

    // Threshold interrupt
    cyc(0, 0, 2, 2'd2, 32'h0301);
    cyc(1, 32'h11, 0, 2'd0, 0);
    cyc(1, 32'h22, 0, 2'd0, 0);
    check("t4_irq_low", {31'h0, irq}, 32'h0);
    cyc(1, 32'h33, 0, 2'd0, 0);
    check("t4_irq_high", {31'h0, irq}, 32'h1);
    cyc(0, 0, 1, 2'd0, 0);
    check("t4_irq_fall", {31'h0, irq}, 32'h0);
    cyc(0, 0, 2, 2'd2, 32'h0);
    drain();

    // Flush with concurrent push
    for (int i = 0; i < 5; i++) cyc(1, 32'h500 + i, 0, 2'd0, 0);
    cyc(1, 32'h5FF, 2, 2'd3, 32'h1);
    in_valid = 0;
    check("t5_ready", {31'h0, in_ready}, 32'h1);
    read_status("t5_empty", 32'h0000_0001);
    cyc(0, 0, 1, 2'd3, 0);

    // Asynchronous reset mid-burst
    cyc(0, 0, 2, 2'd2, 32'h0101);
    for (int i = 0; i < 4; i++) cyc(1, 32'h700 + i, 0, 2'd0, 0);
    cyc(1, 32'h704, 1, 2'd1, 0);
    check("t6_irq_before", {31'h0, irq}, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_readdata", readdata, 32'h0);
    check("t6_rst_irq", {31'h0, irq}, 32'h0);
    check("t6_rst_ready", {31'h0, in_ready}, 32'h1);
    model_reset();
    in_valid = 0; chipselect = 0; read_n = 1; write_n = 1;
    @(negedge clk);
    reset_n = 1'b1;
    read_status("t6_status", 32'h0000_0001);
    cyc(0, 0, 1, 2'd2, 0);
    check("t6_control", readdata, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int op, sel;
      logic [31:0] wd;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 0 : (sel < 8) ? 1 : 2;
      wd  = $urandom;
      if (op == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      cyc(logic'($urandom_range(0, 1)), $urandom, op, 2'($urandom_range(0, 3)), wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
